keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed 8-digit seven-segment driver.
- The display block drives anodes one-hot and pushes segment data out. This block drives the columns of a 4x4 matrix keypad one-hot active-low and reads the rows back in.
- It debounces the readings and emits one-cycle key events (code plus valid pulse) to game logic, e.g. the source of hit/miss decisions feeding the countdown timer.

---
 rtl/game_pkg.sv | 42 ++++
 rtl/sync_2ff.sv | 25 ++
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the board-input blocks (keypad scanner and friends).
package game_pkg;

  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } scan_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_class_t;

  // Zero, one or several keys seen in a 16-bit matrix frame.
  function automatic frame_class_t classify_frame(input logic [15:0] snap);
    frame_class_t c;
    if (snap == 16'd0)
      c = NONE;
    else if ((snap & (snap - 16'd1)) == 16'd0)
      c = SINGLE;
    else
      c = MULTI;
    return c;
  endfunction

  // Index of the lowest set bit; only meaningful when the frame is SINGLE.
  function automatic logic [KEY_CODE_W-1:0] frame_code(input logic [15:0] snap);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (snap[i])
        idx = KEY_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones
// so idle pulled-up lines read as inactive.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Shift the raw input through two flops before anyone uses it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns one-hot active-low, samples rows,
// debounces whole-matrix frames and emits press/release events.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | no key accepted, waiting for a frame with exactly one key
// DEB_PRESS | same single key seen for cnt consecutive frames
// PRESSED   | key accepted and held; other keys ignored until full release
// DEB_REL   | empty frames seen for cnt consecutive frames
module keypad_scanner
  import game_pkg::*;
#(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int N_COLS          = 4,
  parameter int N_ROWS          = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_ROWS-1:0]     row_n,
  output logic [N_COLS-1:0]     col_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held,
  output logic                  key_release
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [N_ROWS-1:0]          row_s;
  logic [DW-1:0]              dwell;
  logic [1:0]                 col_idx;
  logic [1:0]                 col_next;
  logic [15:0]                snapshot;
  logic                       frame_done;
  logic                       tick;
  scan_state_t                state;
  logic [CW-1:0]              cnt;
  logic [CW-1:0]              cnt_inc;
  logic [KEY_CODE_W-1:0]      cand;
  frame_class_t               fclass;
  logic [KEY_CODE_W-1:0]      fcode;

  sync_2ff #(.WIDTH(N_ROWS)) u_row_sync (
    .clock (clock),
    .reset (reset),
    .d     (row_n),
    .q     (row_s)
  );

  assign tick     = (dwell == DWELL_LAST);
  assign col_next = col_idx + 2'd1;
  assign fclass   = classify_frame(snapshot);
  assign fcode    = frame_code(snapshot);
  assign cnt_inc  = (cnt < CNT_MAX) ? cnt + CNT_ONE : cnt;

  // Column dwell timer, row sampling into the frame snapshot, column advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell      <= '0;
      col_idx    <= 2'd0;
      col_n      <= 4'b1110;
      snapshot   <= 16'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (col_idx == 2'd3);
      if (tick) begin
        dwell <= '0;
        for (int r = 0; r < N_ROWS; r++)
          snapshot[r*N_COLS + int'(col_idx)] <= ~row_s[r];
        col_idx <= col_next;
        col_n   <= ~(4'b0001 << col_next);
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Debounce FSM, advanced once per completed frame; event outputs pulse one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (frame_done) begin
        case (state)
          IDLE: begin
            if (fclass == SINGLE) begin
              cand <= fcode;
              if (DEBOUNCE_FRAMES == 1) begin
                state     <= PRESSED;
                cnt       <= '0;
                key_code  <= fcode;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state <= DEB_PRESS;
                cnt   <= CNT_ONE;
              end
            end
          end
          DEB_PRESS: begin
            if (fclass == SINGLE && fcode == cand) begin
              if (cnt_inc == CNT_MAX) begin
                state     <= PRESSED;
                cnt       <= '0;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (fclass == SINGLE) begin
              cand <= fcode;
              cnt  <= CNT_ONE;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (fclass == NONE) begin
              if (DEBOUNCE_FRAMES == 1) begin
                state       <= IDLE;
                cnt         <= '0;
                key_release <= 1'b1;
                key_held    <= 1'b0;
              end else begin
                state <= DEB_REL;
                cnt   <= CNT_ONE;
              end
            end else if (fclass == SINGLE && fcode == cand) begin
              cnt <= '0;
            end
          end
          DEB_REL: begin
            if (fclass == NONE) begin
              if (cnt_inc == CNT_MAX) begin
                state       <= IDLE;
                cnt         <= '0;
                key_release <= 1'b1;
                key_held    <= 1'b0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a small 4x4 keypad model and an event scoreboard.
module tb_keypad_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_release;

  logic [15:0] keys;
  logic [4:0]  exp_q[$];
  int          n_checks;
  int          n_fail;

  localparam int FRAME = 16;
  localparam logic [4:0] EV_RELEASE = 5'h10;
  localparam logic [4:0] EV_NONE    = 5'h1F;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Ideal switch matrix: a row is pulled low when a pressed key sits on a driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every event pulse must match the next queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (key_valid || key_release)
        check_val("valid_and_release_exclusive", 32'(key_valid & key_release), 32'd0);
      if (key_valid) begin
        if (exp_q.size() == 0)
          check_val("unexpected_valid", 32'({1'b0, key_code}), 32'(EV_NONE));
        else
          check_val("valid_event", 32'({1'b0, key_code}), 32'(exp_q.pop_front()));
      end
      if (key_release) begin
        if (exp_q.size() == 0)
          check_val("unexpected_release", 32'(EV_RELEASE), 32'(EV_NONE));
        else
          check_val("release_event", 32'(EV_RELEASE), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(posedge clock);
    @(negedge clock);
  endtask

  // Return just after a frame boundary (column 0 freshly driven).
  task automatic align_frame();
    int budget;
    budget = 0;
    do begin @(negedge clock); budget++; end while (col_n != 4'b0111 && budget < 64);
    do begin @(negedge clock); budget++; end while (col_n != 4'b1110 && budget < 64);
    if (budget >= 64)
      check_val("align_timeout", 32'(budget), 32'd0);
  endtask

  task automatic check_drained(input string tag);
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    keys     = 16'h0000;
    reset    = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_col_n", 32'(col_n), 32'hE);
    check_val("rst_key_code", 32'(key_code), 32'd0);
    check_val("rst_key_valid", 32'(key_valid), 32'd0);
    check_val("rst_key_held", 32'(key_held), 32'd0);
    check_val("rst_key_release", 32'(key_release), 32'd0);
    reset = 1'b0;

    // 1: column walk and quiet keypad
    for (int i = 0; i < 8; i++) begin
      logic [3:0] one;
      one = 4'b0001;
      repeat (4) @(posedge clock);
      @(negedge clock);
      check_val("col_walk", 32'(col_n), 32'(~(one << ((i + 1) % 4)) & 4'hF));
    end
    wait_frames(10);
    check_val("idle_held", 32'(key_held), 32'd0);
    check_drained("t1_drained");

    // 2: key 6 accepted once
    align_frame();
    keys = 16'h0040;
    exp_q.push_back(5'd6);
    wait_frames(3);
    check_drained("t2_press_seen");
    check_val("t2_code", 32'(key_code), 32'd6);
    check_val("t2_held", 32'(key_held), 32'd1);
    wait_frames(5);
    check_val("t2_still_held", 32'(key_held), 32'd1);

    // 3: release, then re-press and bounce one empty frame
    align_frame();
    keys = 16'h0000;
    exp_q.push_back(EV_RELEASE);
    wait_frames(3);
    check_drained("t3_release_seen");
    check_val("t3_held_after_rel", 32'(key_held), 32'd0);
    align_frame();
    keys = 16'h0040;
    exp_q.push_back(5'd6);
    wait_frames(3);
    check_drained("t3_repress_seen");
    align_frame();
    keys = 16'h0000;
    align_frame();
    keys = 16'h0040;
    wait_frames(3);
    check_val("t3_bounce_held", 32'(key_held), 32'd1);
    check_drained("t3_bounce_no_event");
    align_frame();
    keys = 16'h0000;
    exp_q.push_back(EV_RELEASE);
    wait_frames(3);
    check_drained("t3_final_release");

    // 4: key 3 for one frame then key 9
    align_frame();
    keys = 16'h0008;
    align_frame();
    keys = 16'h0200;
    exp_q.push_back(5'd9);
    wait_frames(3);
    check_drained("t4_press_seen");
    check_val("t4_code", 32'(key_code), 32'd9);
    align_frame();
    keys = 16'h0000;
    exp_q.push_back(EV_RELEASE);
    wait_frames(3);
    check_drained("t4_release_seen");

    // 5: multi-key from idle, then rollover while 5 held
    align_frame();
    keys = 16'h0021;
    wait_frames(4);
    check_val("t5_multi_held", 32'(key_held), 32'd0);
    check_val("t5_multi_code", 32'(key_code), 32'd9);
    align_frame();
    keys = 16'h0020;
    exp_q.push_back(5'd5);
    wait_frames(3);
    check_drained("t5_press5_seen");
    keys = 16'h0021;
    wait_frames(4);
    check_val("t5_rollover_code", 32'(key_code), 32'd5);
    check_val("t5_rollover_held", 32'(key_held), 32'd1);
    align_frame();
    keys = 16'h0000;
    exp_q.push_back(EV_RELEASE);
    wait_frames(3);
    check_drained("t5_release_seen");

    // 6: reset during press debounce of key 12
    align_frame();
    keys = 16'h1000;
    align_frame();
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check_val("t6_rst_col_n", 32'(col_n), 32'hE);
    check_val("t6_rst_key_code", 32'(key_code), 32'd0);
    check_val("t6_rst_key_held", 32'(key_held), 32'd0);
    check_val("t6_rst_key_valid", 32'(key_valid), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(5'd12);
    n = 0;
    do begin @(negedge clock); n++; end while (!key_valid && n < 200);
    check_val("t6_latency_after_reset", 32'(n), 32'd33);
    @(negedge clock);
    check_drained("t6_press_seen");
    check_val("t6_code", 32'(key_code), 32'd12);
    keys = 16'h0000;
    exp_q.push_back(EV_RELEASE);
    wait_frames(4);
    check_drained("t6_release_seen");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
